// File: rtl/ram_burst_arbiter_pkg.sv
// Shared types and sizing helpers for the capture-RAM burst arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } arb_state_e;

  // Burst length in words.
  function automatic int BL(input int burst_index);
    return 1 << burst_index;
  endfunction

  // Number of whole bursts the RAM holds.
  function automatic int NB(input int address_width, input int burst_index);
    return 1 << (address_width - burst_index);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the last-grant register moves only when a grant is issued.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // Reset favours requester a by recording b as the last winner.
  logic last_b;

  always_comb begin
    gnt_a = en & req_a & (~req_b | last_b);
    gnt_b = en & req_b & ~gnt_a;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_burst_arbiter.sv
// Burst arbiter sharing the single-port capture RAM between writer and reader as a circular burst buffer.
// Optional sticky overflow flag: define RAM_ARB_OVERFLOW_EN.
module ram_burst_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 14,
  parameter int MAX_RAM_ADDRESS = 16384,
  parameter int BURST_INDEX     = 8,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 flush,
  input  logic                                 wr_req,
  output logic                                 wr_gnt,
  output logic                                 wr_take,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 rd_req,
  output logic                                 rd_gnt,
  output logic                                 rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [ADDRESS_WIDTH-1:0]             ram_addr,
  output logic                                 ram_we,
  output logic [DATA_WIDTH-1:0]                ram_wdata,
  input  logic [DATA_WIDTH-1:0]                ram_rdata,
  output logic [ADDRESS_WIDTH-BURST_INDEX:0]   fill,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 overflow,
  output logic [1:0]                           dbg_state
);

  localparam int PTR_W      = ADDRESS_WIDTH + 1;
  localparam int FILL_W     = ADDRESS_WIDTH - BURST_INDEX + 1;
  localparam int NUM_BURSTS = MAX_RAM_ADDRESS / BL(BURST_INDEX);

  arb_state_e               state;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         ptr_diff;
  logic [BURST_INDEX-1:0]   beat;
  logic [ADDRESS_WIDTH-1:0] addr_hold;
  logic                     last_beat;
  logic                     arb_en;
  logic                     pick_wr;
  logic                     pick_rd;

  // Handshake: a requester holds req until it sees its gnt pulse; gnt coincides with the
  // first beat, and requests are only looked at while the FSM is IDLE.
  assign ptr_diff  = wr_ptr - rd_ptr;
  assign fill      = ptr_diff[PTR_W-1:BURST_INDEX];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (fill == FILL_W'(NUM_BURSTS));
  assign last_beat = &beat;
  assign arb_en    = (state == IDLE) & enable & ~flush;
  assign ram_wdata = wr_data;
  assign dbg_state = state;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req_a   (wr_req & ~full),
    .req_b   (rd_req & ~empty),
    .gnt_a   (pick_wr),
    .gnt_b   (pick_rd)
  );

  always_comb begin
    ram_we   = 1'b0;
    wr_take  = 1'b0;
    ram_addr = addr_hold;
    case (state)
      WR_BURST: begin
        ram_we   = 1'b1;
        wr_take  = 1'b1;
        ram_addr = wr_ptr[ADDRESS_WIDTH-1:0];
      end
      RD_BURST: ram_addr = rd_ptr[ADDRESS_WIDTH-1:0];
      default:  ram_addr = addr_hold;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat      <= '0;
      addr_hold <= '0;
      wr_gnt    <= 1'b0;
      rd_gnt    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      wr_gnt   <= 1'b0;
      rd_gnt   <= 1'b0;
      rd_valid <= (state == RD_BURST);
      case (state)
        IDLE: begin
          beat <= '0;
          if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else if (pick_wr) begin
            wr_gnt <= 1'b1;
            state  <= WR_BURST;
          end else if (pick_rd) begin
            rd_gnt <= 1'b1;
            state  <= RD_BURST;
          end
        end
        WR_BURST: begin
          addr_hold <= wr_ptr[ADDRESS_WIDTH-1:0];
          wr_ptr    <= wr_ptr + PTR_W'(1);
          beat      <= beat + BURST_INDEX'(1);
          if (last_beat) state <= IDLE;
        end
        RD_BURST: begin
          addr_hold <= rd_ptr[ADDRESS_WIDTH-1:0];
          rd_ptr    <= rd_ptr + PTR_W'(1);
          rd_data   <= ram_rdata;
          beat      <= beat + BURST_INDEX'(1);
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_ARB_OVERFLOW_EN
  logic ovf_q;

  // Sticky: a writer knocking on a full buffer means captured results were lost upstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE) begin
      if (flush) begin
        ovf_q <= 1'b0;
      end else if (enable && wr_req && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Scoreboard bench for ram_burst_arbiter at ADDRESS_WIDTH=4, BURST_INDEX=2 (BL=4, NB=4).
module tb_ram_burst_arbiter;
  import ram_arb_pkg::*;

  localparam int AW  = 4;
  localparam int MAXA = 16;
  localparam int BI  = 2;
  localparam int DW  = 32;
  localparam int BLN = 4;
  localparam int FW  = AW - BI + 1;
`ifdef RAM_ARB_OVERFLOW_EN
  localparam logic EXP_OVF_FULL = 1'b1;
`else
  localparam logic EXP_OVF_FULL = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          flush;
  logic          wr_req;
  logic          wr_gnt;
  logic          wr_take;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [FW-1:0] fill;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [1:0]    dbg_state;

  ram_burst_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .MAX_RAM_ADDRESS (MAXA),
    .BURST_INDEX     (BI),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .flush     (flush),
    .wr_req    (wr_req),
    .wr_gnt    (wr_gnt),
    .wr_take   (wr_take),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .fill      (fill),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM and writer models ----------------
  logic [DW-1:0] mem [MAXA];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  function automatic logic [DW-1:0] pattern(input int unsigned s);
    return 32'hC0DE_0000 + s;
  endfunction

  int unsigned wr_seq;
  initial begin
    wr_seq  = 0;
    wr_data = pattern(0);
  end
  always @(posedge clk) begin
    if (wr_take) begin
      #1;
      wr_seq  = wr_seq + 1;
      wr_data = pattern(wr_seq);
    end
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [DW-1:0]    exp_rd_q[$];
  logic [DW-1:0]    model_buf[$];
  int unsigned      m_wptr;
  int unsigned      m_seq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_beat: unexpected write addr %0h data %0h", ram_addr, ram_wdata);
        end else begin
          check("wr_beat", {27'd0, wr_take, ram_addr, ram_wdata}, {27'd0, 1'b1, exp_wr_q.pop_front()});
        end
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data: unexpected rd_valid data %0h", rd_data);
        end else begin
          check("rd_data", {32'd0, rd_data}, {32'd0, exp_rd_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_write(input int nbeats, input bit keep);
    for (int i = 0; i < nbeats; i++) begin
      exp_wr_q.push_back({AW'(m_wptr), pattern(m_seq)});
      if (keep) model_buf.push_back(pattern(m_seq));
      m_wptr = (m_wptr + 1) % MAXA;
      m_seq++;
    end
  endtask

  task automatic push_read();
    for (int i = 0; i < BLN; i++) begin
      if (model_buf.size() == 0) begin
        checks++; errors++;
        $display("FAIL model: read requested from empty model");
      end else begin
        exp_rd_q.push_back(model_buf.pop_front());
      end
    end
  endtask

  task automatic wait_gnt(input bit is_wr, output int lat);
    bit found;
    found = 0;
    lat = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      lat++;
      if (is_wr ? wr_gnt : rd_gnt) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s_gnt_timeout: got none expected grant within 40 cycles", is_wr ? "wr" : "rd");
    end
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (dbg_state == IDLE) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL idle_timeout: state %0d expected IDLE", dbg_state);
    end
  endtask

  task automatic write_burst();
    int lat;
    push_write(BLN, 1'b1);
    wr_req = 1'b1;
    wait_gnt(1'b1, lat);
    wr_req = 1'b0;
    wait_idle();
  endtask

  task automatic read_burst();
    int lat;
    logic [5:0] vpat;
    push_read();
    rd_req = 1'b1;
    wait_gnt(1'b0, lat);
    rd_req = 1'b0;
    vpat[0] = rd_valid;
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      vpat[i] = rd_valid;
    end
    check("rd_valid_pattern", {58'd0, vpat}, {58'd0, 6'b011110});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int ngr;
    int gap_t;
    logic [3:0] gseq;
    int gcyc[4];
    int nw;

    checks = 0; errors = 0;
    m_wptr = 0; m_seq = 0;
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("rst_fill", {61'd0, fill}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_we_addr", {59'd0, ram_we, ram_addr}, 64'd0);
    check("rst_gnt_valid", {61'd0, wr_gnt, rd_gnt, rd_valid}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    enable = 1'b1;

    // 1: first write burst, grant one cycle after request
    @(posedge clk); #1;
    push_write(BLN, 1'b1);
    wr_req = 1'b1;
    wait_gnt(1'b1, lat);
    wr_req = 1'b0;
    check("t1_gnt_latency", 64'(lat), 64'd1);
    wait_idle();
    check("t1_fill", {61'd0, fill}, 64'd1);
    check("t1_empty", {63'd0, empty}, 64'd0);

    // 2: read it back
    read_burst();
    check("t2_empty", {63'd0, empty}, 64'd1);

    // 3: fill=2 with reader as last winner, then hold both requests
    write_burst(); write_burst(); write_burst();
    read_burst();
    check("t3_fill_pre", {61'd0, fill}, 64'd2);
    push_write(BLN, 1'b1); push_read();
    push_write(BLN, 1'b1); push_read();
    wr_req = 1'b1; rd_req = 1'b1;
    ngr = 0; gseq = '0; nw = 0;
    for (int c = 0; c < 80 && ngr < 4; c++) begin
      @(posedge clk); #1;
      if (wr_gnt || rd_gnt) begin
        gseq[ngr] = wr_gnt;
        gcyc[ngr] = c;
        ngr++;
        if (ngr == 4) begin
          wr_req = 1'b0; rd_req = 1'b0;
        end
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("t3_grant_count", 64'(ngr), 64'd4);
    check("t3_grant_order", {60'd0, gseq}, {60'd0, 4'b0101});
    for (int i = 1; i < 4; i++) begin
      gap_t = (i < ngr) ? gcyc[i] - gcyc[i-1] : 0;
      check("t3_grant_gap", 64'(gap_t), 64'd5);
    end
    wait_idle();
    @(posedge clk); #1;
    check("t3_fill_post", {61'd0, fill}, 64'd2);

    // 4: drain, then fill to full; a fifth request is refused
    read_burst(); read_burst();
    check("t4_empty", {63'd0, empty}, 64'd1);
    repeat (4) write_burst();
    check("t4_full", {63'd0, full}, 64'd1);
    check("t4_fill", {61'd0, fill}, 64'd4);
    check("t4_ovf_before", {63'd0, overflow}, 64'd0);
    wr_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (wr_gnt) nw++;
    end
    wr_req = 1'b0;
    check("t4_no_grant_full", 64'(nw), 64'd0);
    check("t4_overflow", {63'd0, overflow}, {63'd0, EXP_OVF_FULL});
    repeat (4) read_burst();
    check("t4_empty_after", {62'd0, empty, full}, 64'd2);
    check("t4_ovf_sticky", {63'd0, overflow}, {63'd0, EXP_OVF_FULL});

    // 5: refill across address 15 -> 0
    repeat (3) write_burst();
    check("t5_fill", {61'd0, fill}, 64'd3);
    check("t5_full_empty", {62'd0, full, empty}, 64'd0);

    // flush with fill=3 while a write is requested
    flush = 1'b1; wr_req = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wr_req = 1'b0;
    check("flush_no_grant", {63'd0, wr_gnt}, 64'd0);
    check("flush_fill", {61'd0, fill}, 64'd0);
    check("flush_empty", {63'd0, empty}, 64'd1);
    check("flush_ovf_clear", {63'd0, overflow}, 64'd0);
    model_buf.delete();
    m_wptr = 0;
    write_burst();
    read_burst();

    // 6: reset at beat 2 of a write
    push_write(2, 1'b0);
    wr_req = 1'b1;
    wait_gnt(1'b1, lat);
    wr_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_mid_burst_addr", {60'd0, ram_addr}, 64'd6);
    reset_n = 1'b0;
    #1;
    check("t6_rst_outputs", {57'd0, ram_we, wr_take, wr_gnt, rd_valid, dbg_state, 1'b0}, 64'd0);
    check("t6_rst_addr_fill", {57'd0, ram_addr, fill}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("t6_fill", {61'd0, fill}, 64'd0);
    check("t6_empty", {63'd0, empty}, 64'd1);
    model_buf.delete();
    m_wptr = 0;
    write_burst();
    read_burst();

    repeat (3) @(posedge clk);
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
